id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
// ID/EX pipeline stage directly downstream of the 32x64 register file. Captures ReadData1/ReadData2
// plus decoded control, and bypasses the same-cycle WB write that the register file does not pass through.
// Supplies forwarded ALU operands from the EX/MEM and MEM/WB results, detects load-use hazards,
// stalls IF/ID and inserts bubbles. X31 is hard zero: it is never forwarded and never causes a hazard.
// PARAMETERS
// DATA_W    64  operand/result width
// REG_AW    5   register index width
// ZERO_REG  31  index that always reads zero (XZR)
// PORTS
// clk          in   1       rising-edge clock
// reset        in   1       synchronous, active-high
// in_valid     in   1       ID holds a real instruction
// in_rs1       in   REG_AW  ReadRegister1 sent to the register file
// in_rs2       in   REG_AW  ReadRegister2 sent to the register file
// in_uses_rs2  in   1       instruction reads rs2 (0 for immediate forms)
// in_rd1       in   DATA_W  register file ReadData1
// in_rd2       in   DATA_W  register file ReadData2
// in_rd        in   REG_AW  destination register
// in_regwrite  in   1       instruction writes rd
// in_memread   in   1       instruction is a load
// flush        in   1       branch taken; squash the ID instruction
// exm_rd       in   REG_AW  EX/MEM destination register
// exm_regwrite in   1       EX/MEM writes rd
// exm_result   in   DATA_W  EX/MEM ALU result
// wb_rd        in   REG_AW  WB destination register (= register file WriteRegister)
// wb_regwrite  in   1       WB write enable (= register file RegWrite)
// wb_data      in   DATA_W  WB data (= register file WriteData)
// out_valid    out  1       EX holds a real instruction
// out_opA      out  DATA_W  forwarded operand A
// out_opB      out  DATA_W  forwarded operand B
// out_rd       out  REG_AW  registered rd
// out_regwrite out  1       registered regwrite, forced to 0 in a bubble
// out_memread  out  1       registered memread, forced to 0 in a bubble
// stall        out  1       combinational; hold PC and IF/ID this cycle
// stall_cnt    out  32      saturating count of stall cycles
// BEHAVIOUR
// - Reset (synchronous, takes priority): all registered state = 0. out_valid=0, out_rd=0,
//   out_opA=out_opB=0, stall_cnt=0. stall=0 while out_valid=0.
// - Input bypass at capture: if wb_regwrite && wb_rd==in_rsN && in_rsN!=ZERO_REG, capture wb_data;
//   otherwise capture in_rdN.
// - stall = out_valid & out_memread & out_rd!=ZERO_REG & in_valid & !flush
//   & (in_rs1==out_rd | (in_uses_rs2 & in_rs2==out_rd)).
// - Each posedge: reset has priority, then flush or stall, then normal load.
//   - flush or stall: load a bubble. Valid, regwrite and memread = 0; the data fields may hold any value.
//   - otherwise: load the ID fields. Valid, regwrite and memread are ANDed with in_valid.
//   - The load-use stall therefore lasts exactly 1 cycle. The stage has 1-cycle latency.
// - Output forwarding, combinational per operand N, in priority order:
//   1. exm_result if exm_regwrite && exm_rd==rsN_q && rsN_q!=ZERO_REG
//   2. else wb_data if wb_regwrite && wb_rd==rsN_q && rsN_q!=ZERO_REG
//   3. else the captured value
//   A captured index of ZERO_REG always yields 0. The bubble's operand values are don't-care.
// - stall_cnt increments when stall=1 and saturates at 32'hFFFF_FFFF.
// - Simultaneous flush and hazard: flush wins, stall=0, stall_cnt is unchanged.
// STRUCTURE
// - Shared pkg cpu_pkg: DATA_W, REG_AW, ZERO_REG constants and the typedef struct idex_ctrl_t
//   {valid, regwrite, memread, rd}.
// - One sub-module, fwd_mux: a 3:1 priority operand select. Instantiated twice, for A and for B.
// TESTING
// - Reset mid-stream: pipe full, assert reset for 1 cycle -> next cycle out_valid=0, stall=0, stall_cnt=0.
// - WB bypass: wb writes X5=0xAB while ID reads rs1=5 with stale in_rd1=0x11 -> out_opA=0xAB next cycle.
// - EX/MEM vs WB priority: exm_rd=3 (0x100) and wb_rd=3 (0x200) both write, rs2_q=3
//   -> out_opB=0x100.
// - Load-use: LDUR X2 is in EX and ID reads rs1=2 -> stall=1 for exactly 1 cycle, one bubble
//   (out_regwrite=0), stall_cnt=1.
// - XZR: exm_rd=31 writes 0xFF and rs1=31 -> out_opA=0; a load to X31 followed by a read of X31
//   -> stall=0.
// - Flush+hazard: load-use condition with flush=1 -> stall=0, bubble inserted, stall_cnt unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and the ID/EX control bundle for the operand stage.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rd;
  } idex_ctrl_t;

  // True when a writer with enable en and destination dst produces the value for source src.
  // XZR is never produced by anybody, so it never matches.
  function automatic logic hitsReg(input logic en,
                                   input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] src);
    return en && (dst == src) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// 3:1 priority operand select: EX/MEM result, then WB data, then the captured value.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs,
  input  logic [DATA_W-1:0] i_captured,
  input  logic              i_exm_regwrite,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic [DATA_W-1:0] i_exm_result,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_operand
);

  // The youngest producer wins; XZR always reads zero regardless of what was captured.
  always_comb begin
    o_operand = i_captured;
    if (i_rs == ZERO_REG) begin
      o_operand = '0;
    end else if (hitsReg(i_exm_regwrite, i_exm_rd, i_rs)) begin
      o_operand = i_exm_result;
    end else if (hitsReg(i_wb_regwrite, i_wb_rd, i_rs)) begin
      o_operand = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with same-cycle WB bypass on capture, EX-side operand forwarding,
// load-use hazard detection and a saturating stall counter.
module id_ex_operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_uses_rs2,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              flush,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_regwrite,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              stall,
  output logic [31:0]       stall_cnt
);

  idex_ctrl_t        r_ctrl;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [DATA_W-1:0] r_capA;
  logic [DATA_W-1:0] r_capB;
  logic [31:0]       r_stall_cnt;

  idex_ctrl_t        w_next_ctrl;
  logic [DATA_W-1:0] w_capA;
  logic [DATA_W-1:0] w_capB;
  logic              w_src_match;

  // A load in EX whose destination is read by the instruction in ID forces one bubble.
  assign w_src_match = (in_rs1 == r_ctrl.rd) | (in_uses_rs2 & (in_rs2 == r_ctrl.rd));
  assign stall = r_ctrl.valid & r_ctrl.memread & (r_ctrl.rd != ZERO_REG)
               & in_valid & ~flush & w_src_match;

  // The register file does not pass a same-cycle write through, so bypass it here.
  assign w_capA = hitsReg(wb_regwrite, wb_rd, in_rs1) ? wb_data : in_rd1;
  assign w_capB = hitsReg(wb_regwrite, wb_rd, in_rs2) ? wb_data : in_rd2;

  // Control for the next EX instruction: a bubble on flush or stall, else the qualified ID fields.
  always_comb begin
    w_next_ctrl.valid    = in_valid;
    w_next_ctrl.regwrite = in_regwrite & in_valid;
    w_next_ctrl.memread  = in_memread & in_valid;
    w_next_ctrl.rd       = in_rd;
    if (flush || stall) begin
      w_next_ctrl.valid    = 1'b0;
      w_next_ctrl.regwrite = 1'b0;
      w_next_ctrl.memread  = 1'b0;
    end
  end

  // Pipeline register and stall counter; data fields load every cycle since bubbles ignore them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_capA      <= '0;
      r_capB      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ctrl <= w_next_ctrl;
      r_rs1  <= in_rs1;
      r_rs2  <= in_rs2;
      r_capA <= w_capA;
      r_capB <= w_capB;
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  fwd_mux u_fwd_a (
    .i_rs           (r_rs1),
    .i_captured     (r_capA),
    .i_exm_regwrite (exm_regwrite),
    .i_exm_rd       (exm_rd),
    .i_exm_result   (exm_result),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_rd        (wb_rd),
    .i_wb_data      (wb_data),
    .o_operand      (out_opA)
  );

  fwd_mux u_fwd_b (
    .i_rs           (r_rs2),
    .i_captured     (r_capB),
    .i_exm_regwrite (exm_regwrite),
    .i_exm_rd       (exm_rd),
    .i_exm_result   (exm_result),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_rd        (wb_rd),
    .i_wb_data      (wb_data),
    .o_operand      (out_opB)
  );

  assign out_valid    = r_ctrl.valid;
  assign out_regwrite = r_ctrl.regwrite;
  assign out_memread  = r_ctrl.memread;
  assign out_rd       = r_ctrl.rd;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: each driven cycle pushes the expected EX contents,
// which are popped and compared (with forwarding applied) on the following cycle.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs2, in_regwrite, in_memread, flush;
  logic [63:0] in_rd1, in_rd2;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_regwrite, wb_regwrite;
  logic [63:0] exm_result, wb_data;
  logic        out_valid, out_regwrite, out_memread, stall;
  logic [63:0] out_opA, out_opB;
  logic [4:0]  out_rd;
  logic [31:0] stall_cnt;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] capA;
    logic [63:0] capB;
    logic        chk;
  } exp_t;

  exp_t        scoreboard[$];
  logic [31:0] cntModel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_uses_rs2(in_uses_rs2), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .flush(flush),
    .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .out_valid(out_valid), .out_opA(out_opA), .out_opB(out_opB), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference operand select for the EX-side forwarding, using the current EX/MEM and WB buses.
  function automatic logic [63:0] fwdModel(input logic [4:0] rs, input logic [63:0] cap);
    if (rs == 5'd31) return 64'd0;
    if (exm_regwrite && exm_rd == rs) return exm_result;
    if (wb_regwrite && wb_rd == rs) return wb_data;
    return cap;
  endfunction

  task automatic setId(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic uses2, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_uses_rs2 = uses2;
    in_rd1 = d1; in_rd2 = d2; in_rd = rd; in_regwrite = rw; in_memread = mr;
  endtask

  task automatic clearFwd();
    exm_regwrite = 1'b0; exm_rd = 5'd0; exm_result = 64'd0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
  endtask

  // One clock: compare the EX contents expected from last cycle, then push this cycle's capture.
  task automatic applyStimulus();
    exp_t cur;
    exp_t nxt;
    logic expStall;
    #1;
    cur = scoreboard.pop_front();
    expStall = cur.valid && cur.memread && (cur.rd != 5'd31) && in_valid && !flush &&
               ((in_rs1 == cur.rd) || (in_uses_rs2 && in_rs2 == cur.rd));
    checkOutput("stall", 64'(stall), 64'(expStall));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(cntModel));
    checkOutput("out_valid", 64'(out_valid), 64'(cur.valid));
    checkOutput("out_regwrite", 64'(out_regwrite), 64'(cur.regwrite));
    checkOutput("out_memread", 64'(out_memread), 64'(cur.memread));
    if (cur.valid) checkOutput("out_rd", 64'(out_rd), 64'(cur.rd));
    if (cur.chk) begin
      checkOutput("out_opA", out_opA, fwdModel(cur.rs1, cur.capA));
      checkOutput("out_opB", out_opB, fwdModel(cur.rs2, cur.capB));
    end
    nxt.rs1 = in_rs1;
    nxt.rs2 = in_rs2;
    nxt.rd  = in_rd;
    nxt.capA = (wb_regwrite && wb_rd == in_rs1 && in_rs1 != 5'd31) ? wb_data : in_rd1;
    nxt.capB = (wb_regwrite && wb_rd == in_rs2 && in_rs2 != 5'd31) ? wb_data : in_rd2;
    if (reset) begin
      nxt = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
              capA: 64'd0, capB: 64'd0, chk: 1'b1};
      cntModel = 32'd0;
    end else begin
      if (flush || expStall) begin
        nxt.valid = 1'b0; nxt.regwrite = 1'b0; nxt.memread = 1'b0; nxt.chk = 1'b0;
      end else begin
        nxt.valid = in_valid; nxt.regwrite = in_regwrite & in_valid;
        nxt.memread = in_memread & in_valid; nxt.chk = in_valid;
      end
      if (expStall && cntModel != 32'hFFFF_FFFF) cntModel = cntModel + 32'd1;
    end
    scoreboard.push_back(nxt);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clearFwd();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    scoreboard.push_back('{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, rd: 5'd0, rs1: 5'd0,
                           rs2: 5'd0, capA: 64'd0, capB: 64'd0, chk: 1'b1});
    cntModel = 32'd0;
    applyStimulus();
    reset = 1'b0;

    $display("[TB] plain capture");
    setId(1, 5'd1, 5'd2, 1, 64'h1111, 64'h2222, 5'd4, 1, 0);
    applyStimulus();

    $display("[TB] WB bypass at capture");
    setId(1, 5'd5, 5'd6, 1, 64'h11, 64'h66, 5'd8, 1, 0);
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 64'hAB;
    applyStimulus();
    clearFwd();

    $display("[TB] EX/MEM beats WB");
    setId(1, 5'd9, 5'd3, 1, 64'h999, 64'h333, 5'd10, 1, 0);
    applyStimulus();
    exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 64'h100;
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'h200;
    setId(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    applyStimulus();
    clearFwd();

    $display("[TB] load-use stall");
    setId(1, 5'd1, 5'd1, 0, 64'h40, 0, 5'd2, 1, 1);
    applyStimulus();
    setId(1, 5'd2, 5'd0, 0, 64'h50, 0, 5'd6, 1, 0);
    applyStimulus();
    applyStimulus();
    setId(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    applyStimulus();
    checkOutput("loaduse_cnt", 64'(stall_cnt), 64'd1);

    $display("[TB] XZR handling");
    setId(1, 5'd31, 5'd31, 1, 64'hDEAD, 64'hBEEF, 5'd31, 1, 1);
    applyStimulus();
    exm_regwrite = 1'b1; exm_rd = 5'd31; exm_result = 64'hFF;
    setId(1, 5'd31, 5'd31, 1, 0, 0, 5'd12, 1, 0);
    applyStimulus();
    clearFwd();
    setId(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    applyStimulus();

    $display("[TB] flush with hazard");
    setId(1, 5'd1, 5'd1, 0, 0, 0, 5'd7, 1, 1);
    applyStimulus();
    setId(1, 5'd7, 5'd7, 1, 64'h77, 64'h77, 5'd13, 1, 0);
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    setId(1, 5'd14, 5'd15, 1, 64'h14, 64'h15, 5'd16, 1, 0);
    applyStimulus();

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      setId(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 7) == 0);
      exm_regwrite = 1'($urandom_range(0, 1));
      exm_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      exm_result = {$urandom, $urandom};
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      applyStimulus();
    end
    flush = 1'b0;
    clearFwd();

    $display("[TB] reset mid-stream");
    setId(1, 5'd1, 5'd2, 1, 64'h5, 64'h6, 5'd3, 1, 1);
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    setId(1, 5'd0, 5'd0, 1, 0, 0, 5'd1, 1, 0);
    applyStimulus();
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
